lsu_stream_address_sequencer: RTL and testbench

//  Upstream feeder for the streaming prefetch read unit. Accepts one stream command (base, thread count, stride, nop flag).

---
 rtl/lsu_stream_pkg.sv | 21 ++
 rtl/lsu_stream_address_sequencer.sv | 106 ++++++++++
 tb/tb_lsu_stream_address_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_stream_pkg.sv
// Shared types, default constants and address-step helper for the stream address sequencer.
package lsu_stream_pkg;

  localparam int unsigned DEF_AWIDTH          = 32;
  localparam int unsigned DEF_WIDTH_BYTES     = 32;
  localparam int unsigned DEF_ALIGNMENT_ABITS = 5;
  localparam int unsigned DEF_COUNT_WIDTH     = 16;
  localparam int unsigned DEF_STRIDE_WIDTH    = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Byte step from an already sign-extended word stride; caller truncates to AWIDTH (mod 2^AWIDTH).
  function automatic logic [63:0] stride_step(input logic [63:0] stride_sx,
                                              input int unsigned abits);
    return stride_sx << abits;
  endfunction

endpackage

// File: rtl/lsu_stream_address_sequencer.sv
// Expands one stream command (base, count, stride, nop) into per-thread requests
// for the streaming prefetch read unit, under its stall handshake.
module lsu_stream_address_sequencer
  import lsu_stream_pkg::*;
#(
  parameter int unsigned AWIDTH          = DEF_AWIDTH,
  parameter int unsigned WIDTH_BYTES     = DEF_WIDTH_BYTES,
  parameter int unsigned ALIGNMENT_ABITS = DEF_ALIGNMENT_ABITS,
  parameter int unsigned COUNT_WIDTH     = DEF_COUNT_WIDTH,
  parameter int unsigned STRIDE_WIDTH    = DEF_STRIDE_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_stall,
  input  logic [AWIDTH-1:0]              i_cmd_base,
  input  logic [COUNT_WIDTH-1:0]         i_cmd_count,
  input  logic signed [STRIDE_WIDTH-1:0] i_cmd_stride,
  input  logic                           i_cmd_nop,
  output logic                           o_valid,
  output logic [AWIDTH-1:0]              o_address,
  output logic                           o_nop,
  input  logic                           i_stall,
  output logic                           o_cmd_done,
  output logic                           o_busy
);

  localparam logic [AWIDTH-1:0] ALIGN_MASK = ~(AWIDTH'(WIDTH_BYTES) - AWIDTH'(1));

  state_t                 state;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [AWIDTH-1:0]      step;
  logic                   pend_done;

  logic                   last;
  logic                   accept;
  logic                   xfer;
  logic                   cmd_empty;
  logic [AWIDTH-1:0]      base_al;
  logic [AWIDTH-1:0]      step_new;

  // Handshake decode; a new command may enter on the cycle the last request leaves.
  assign last        = (remaining == COUNT_WIDTH'(1));
  assign o_cmd_stall = (state == ISSUE) && !(last && !i_stall);
  assign accept      = i_cmd_valid && !o_cmd_stall;
  assign xfer        = o_valid && !i_stall;
  assign o_busy      = (state == ISSUE);
  assign cmd_empty   = (i_cmd_count == '0);
  assign base_al     = i_cmd_base & ALIGN_MASK;
  assign step_new    = AWIDTH'(stride_step(64'(i_cmd_stride), ALIGNMENT_ABITS));

  // Command FSM with address adder and remaining-request counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      o_valid    <= 1'b0;
      o_nop      <= 1'b0;
      o_cmd_done <= 1'b0;
      o_address  <= '0;
      remaining  <= '0;
      step       <= '0;
      pend_done  <= 1'b0;
    end else begin
      // A zero-count command taken behind a finishing one reports one cycle later.
      o_cmd_done <= pend_done;
      pend_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!cmd_empty) begin
              step      <= step_new;
              remaining <= i_cmd_count;
              o_nop     <= i_cmd_nop;
              o_address <= base_al;
              o_valid   <= 1'b1;
              state     <= ISSUE;
            end else begin
              o_cmd_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (xfer) begin
            if (!last) begin
              o_address <= o_address + step;
              remaining <= remaining - COUNT_WIDTH'(1);
            end else begin
              o_cmd_done <= 1'b1;
              if (accept && !cmd_empty) begin
                step      <= step_new;
                remaining <= i_cmd_count;
                o_nop     <= i_cmd_nop;
                o_address <= base_al;
              end else begin
                o_valid <= 1'b0;
                state   <= IDLE;
                if (accept) pend_done <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stream_address_sequencer.sv
// Directed, table-driven bench for lsu_stream_address_sequencer.
module tb_lsu_stream_address_sequencer;

  logic        clk;
  logic        reset;
  logic        i_cmd_valid;
  logic        o_cmd_stall;
  logic [31:0] i_cmd_base;
  logic [15:0] i_cmd_count;
  logic [15:0] i_cmd_stride;
  logic        i_cmd_nop;
  logic        o_valid;
  logic [31:0] o_address;
  logic        o_nop;
  logic        i_stall;
  logic        o_cmd_done;
  logic        o_busy;

  int total;
  int bad;

  typedef struct {
    logic        cv;
    logic [31:0] base;
    logic [15:0] cnt;
    logic [15:0] stride;
    logic        nop;
    logic        stall;
    logic        ev;
    logic [31:0] ea;
    logic        en;
    logic        ed;
    logic        eb;
    logic        ecs;
  } vec_t;

  vec_t vecs[$];

  lsu_stream_address_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_stall  (o_cmd_stall),
    .i_cmd_base   (i_cmd_base),
    .i_cmd_count  (i_cmd_count),
    .i_cmd_stride (i_cmd_stride),
    .i_cmd_nop    (i_cmd_nop),
    .o_valid      (o_valid),
    .o_address    (o_address),
    .o_nop        (o_nop),
    .i_stall      (i_stall),
    .o_cmd_done   (o_cmd_done),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=0x%08h want=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic cv, input logic [31:0] base, input logic [15:0] cnt,
                     input logic [15:0] stride, input logic nop, input logic stall,
                     input logic ev, input logic [31:0] ea, input logic en,
                     input logic ed, input logic eb, input logic ecs);
    vec_t v;
    v.cv = cv; v.base = base; v.cnt = cnt; v.stride = stride; v.nop = nop; v.stall = stall;
    v.ev = ev; v.ea = ea; v.en = en; v.ed = ed; v.eb = eb; v.ecs = ecs;
    vecs.push_back(v);
  endtask

  // Idle inputs, no stall, with expected outputs.
  task automatic q(input logic stall, input logic ev, input logic [31:0] ea, input logic en,
                   input logic ed, input logic eb, input logic ecs);
    add(1'b0, 32'h0, 16'h0, 16'h0, 1'b0, stall, ev, ea, en, ed, eb, ecs);
  endtask

  task automatic drive_idle();
    i_cmd_valid  = 1'b0;
    i_cmd_base   = 32'h0;
    i_cmd_count  = 16'h0;
    i_cmd_stride = 16'h0;
    i_cmd_nop    = 1'b0;
    i_stall      = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive_idle();

    // Ideal downstream: 0x1000 x4, stride 1
    add(1, 32'h1000, 16'd4, 16'd1, 0, 0,   0, 32'h0,    0, 0, 0, 0);
    q(0, 1, 32'h1000, 0, 0, 1, 1);
    q(0, 1, 32'h1020, 0, 0, 1, 1);
    q(0, 1, 32'h1040, 0, 0, 1, 1);
    q(0, 1, 32'h1060, 0, 0, 1, 0);
    q(0, 0, 32'h0,    0, 1, 0, 0);
    q(0, 0, 32'h0,    0, 0, 0, 0);
    // Unaligned base, stride -2; stall on the last request holds it
    add(1, 32'h103F, 16'd3, 16'hFFFE, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    q(0, 1, 32'h1020, 0, 0, 1, 1);
    q(0, 1, 32'h0FE0, 0, 0, 1, 1);
    q(1, 1, 32'h0FA0, 0, 0, 1, 1);
    q(0, 1, 32'h0FA0, 0, 0, 1, 0);
    q(0, 0, 32'h0,    0, 1, 0, 0);
    // Stall for 5 cycles on the 2nd request
    add(1, 32'h1000, 16'd3, 16'd1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    q(0, 1, 32'h1000, 0, 0, 1, 1);
    for (int k = 0; k < 5; k++) q(1, 1, 32'h1020, 0, 0, 1, 1);
    q(0, 1, 32'h1020, 0, 0, 1, 1);
    q(0, 1, 32'h1040, 0, 0, 1, 0);
    q(0, 0, 32'h0,    0, 1, 0, 0);
    // Back-to-back: second command waits, enters on the last transfer
    add(1, 32'h2000, 16'd2, 16'd1, 0, 0, 0, 32'h0,    0, 0, 0, 0);
    add(1, 32'h8000, 16'd2, 16'd1, 0, 0, 1, 32'h2000, 0, 0, 1, 1);
    add(1, 32'h8000, 16'd2, 16'd1, 0, 0, 1, 32'h2020, 0, 0, 1, 0);
    q(0, 1, 32'h8000, 0, 1, 1, 1);
    q(0, 1, 32'h8020, 0, 0, 1, 0);
    q(0, 0, 32'h0,    0, 1, 0, 0);
    // Zero-count command behind a finishing one: two successive done pulses
    add(1, 32'h3000, 16'd1, 16'd1, 0, 0, 0, 32'h0,    0, 0, 0, 0);
    add(1, 32'h0,    16'd0, 16'd1, 0, 0, 1, 32'h3000, 0, 0, 1, 0);
    q(0, 0, 32'h0, 0, 1, 0, 0);
    q(0, 0, 32'h0, 0, 1, 0, 0);
    q(0, 0, 32'h0, 0, 0, 0, 0);
    // Zero-count command from idle
    add(1, 32'h7000, 16'd0, 16'd1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    q(0, 0, 32'h0, 0, 1, 0, 0);
    q(0, 0, 32'h0, 0, 0, 0, 0);
    // NOP command, count 3
    add(1, 32'h4000, 16'd3, 16'd1, 1, 0, 0, 32'h0, 0, 0, 0, 0);
    q(0, 1, 32'h4000, 1, 0, 1, 1);
    q(0, 1, 32'h4020, 1, 0, 1, 1);
    q(0, 1, 32'h4040, 1, 0, 1, 0);
    q(0, 0, 32'h0,    0, 1, 0, 0);
    // Address wrap
    add(1, 32'hFFFFFFE0, 16'd2, 16'd1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    q(0, 1, 32'hFFFFFFE0, 0, 0, 1, 1);
    q(0, 1, 32'h00000000, 0, 0, 1, 0);
    q(0, 0, 32'h0,        0, 1, 0, 0);

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", -1, 32'(o_valid), 32'd0);
    chk("rst_addr",  -1, o_address,    32'd0);
    chk("rst_nop",   -1, 32'(o_nop),   32'd0);
    chk("rst_done",  -1, 32'(o_cmd_done), 32'd0);
    chk("rst_busy",  -1, 32'(o_busy),  32'd0);
    chk("rst_cstall",-1, 32'(o_cmd_stall), 32'd0);
    @(posedge clk);

    // Table-driven vectors: inputs held for one cycle, outputs checked mid-cycle
    foreach (vecs[i]) begin
      #1;
      i_cmd_valid  = vecs[i].cv;
      i_cmd_base   = vecs[i].base;
      i_cmd_count  = vecs[i].cnt;
      i_cmd_stride = vecs[i].stride;
      i_cmd_nop    = vecs[i].nop;
      i_stall      = vecs[i].stall;
      @(negedge clk);
      chk("valid",  i, 32'(o_valid),     32'(vecs[i].ev));
      chk("done",   i, 32'(o_cmd_done),  32'(vecs[i].ed));
      chk("busy",   i, 32'(o_busy),      32'(vecs[i].eb));
      chk("cstall", i, 32'(o_cmd_stall), 32'(vecs[i].ecs));
      if (vecs[i].ev) begin
        chk("addr", i, o_address,    vecs[i].ea);
        chk("nop",  i, 32'(o_nop),   32'(vecs[i].en));
      end
      @(posedge clk);
    end

    // Reset mid-command: outputs clear, no done pulse afterwards
    #1;
    i_cmd_valid  = 1'b1;
    i_cmd_base   = 32'h5000;
    i_cmd_count  = 16'd5;
    i_cmd_stride = 16'd1;
    i_cmd_nop    = 1'b1;
    i_stall      = 1'b0;
    @(posedge clk);
    #1 drive_idle();
    @(posedge clk);
    @(negedge clk);
    chk("mid_addr0", 100, o_address, 32'h5020);
    chk("mid_valid", 100, 32'(o_valid), 32'd1);
    #4 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_valid",  101, 32'(o_valid),     32'd0);
    chk("mrst_addr",   101, o_address,        32'd0);
    chk("mrst_nop",    101, 32'(o_nop),       32'd0);
    chk("mrst_done",   101, 32'(o_cmd_done),  32'd0);
    chk("mrst_busy",   101, 32'(o_busy),      32'd0);
    chk("mrst_cstall", 101, 32'(o_cmd_stall), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_done",  102 + k, 32'(o_cmd_done), 32'd0);
      chk("post_valid", 102 + k, 32'(o_valid),    32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
